// File: rtl/risc_controller_pkg.sv
// Purpose: shared VeriRISC opcode map, phase encodings and ALU-op membership helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package risc_controller_pkg;

    localparam int PHASES = 8;
    localparam int OP_W   = 3;
    localparam int PH_W   = $clog2(PHASES);

    // Opcode map, shared with the ALU
    localparam logic [OP_W-1:0] OP_HLT = 3'b000;
    localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_LDA = 3'b101;
    localparam logic [OP_W-1:0] OP_STO = 3'b110;
    localparam logic [OP_W-1:0] OP_JMP = 3'b111;

    // Phase encodings of the eight-phase instruction cycle
    localparam logic [PH_W-1:0] PH_INST_ADDR  = 3'd0;
    localparam logic [PH_W-1:0] PH_INST_FETCH = 3'd1;
    localparam logic [PH_W-1:0] PH_INST_LOAD  = 3'd2;
    localparam logic [PH_W-1:0] PH_IDLE       = 3'd3;
    localparam logic [PH_W-1:0] PH_OP_ADDR    = 3'd4;
    localparam logic [PH_W-1:0] PH_OP_FETCH   = 3'd5;
    localparam logic [PH_W-1:0] PH_ALU_OP     = 3'd6;
    localparam logic [PH_W-1:0] PH_STORE      = 3'd7;

    // Opcodes that read an operand from memory and write the accumulator
    function automatic logic is_aluop(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Purpose: bundles the controller's opcode/zero/mem_ready inputs and its control strobes.
// Latency: n/a (wiring only).
// Backpressure: mem_ready from the memory side stretches the controller's wait phases.
interface risc_controller_if;
    import risc_controller_pkg::*;

    logic [OP_W-1:0] opcode;
    logic            zero;
    logic            mem_ready;
    logic            sel;
    logic            rd;
    logic            ld_ir;
    logic            inc_pc;
    logic            ld_pc;
    logic            ld_ac;
    logic            wr;
    logic            data_e;
    logic            halt;
    logic [PH_W-1:0] phase;

    // Controller side: consumes datapath status, produces strobes
    modport master (
        input  opcode, zero, mem_ready,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );

    // Datapath side: produces status, consumes strobes
    modport slave (
        output opcode, zero, mem_ready,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );

endinterface

// File: rtl/risc_phase_counter.sv
// Purpose: wrapping phase counter for the instruction cycle, with hold and freeze.
// Latency: phase advances one step per clock edge when neither hold nor freeze is set.
// Backpressure: i_hold (memory wait) or i_freeze (halt) keep the current phase.
module risc_phase_counter
    import risc_controller_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_hold,
    input  logic            i_freeze,
    output logic [PH_W-1:0] o_phase
);

    logic [PH_W-1:0] r_phase;

    // Advance phase, wrapping after the last phase; hold or freeze keeps it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_INST_ADDR;
        end else if (!(i_hold || i_freeze)) begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/risc_controller.sv
// Purpose: VeriRISC instruction sequencer; Moore decode of phase and opcode into control strobes.
// Latency: one instruction per 8 cycles with mem_ready high; strobes are combinational from state.
// Backpressure: mem_ready low holds phase 1, phase 5 (ALU ops) and phase 7 (STO); halt is sticky.
module risc_controller
    import risc_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    risc_controller_if.master bus
);

    logic [PH_W-1:0] w_phase;
    logic            w_aluop;
    logic            w_is_sto;
    logic            w_is_jmp;
    logic            w_is_skz;
    logic            w_is_hlt;
    logic            w_hold;
    logic            r_halted;

    assign w_aluop  = is_aluop(bus.opcode);
    assign w_is_sto = (bus.opcode == OP_STO);
    assign w_is_jmp = (bus.opcode == OP_JMP);
    assign w_is_skz = (bus.opcode == OP_SKZ);
    assign w_is_hlt = (bus.opcode == OP_HLT);

    // Memory wait: hold only in phases that actually wait on the bus for this opcode
    always_comb begin
        w_hold = 1'b0;
        case (w_phase)
            PH_INST_FETCH: w_hold = !bus.mem_ready;
            PH_OP_FETCH:   w_hold = !bus.mem_ready && w_aluop;
            PH_STORE:      w_hold = !bus.mem_ready && w_is_sto;
            default:       w_hold = 1'b0;
        endcase
    end

    // Sticky halt: set leaving OP_ADDR on HLT; the counter then sits frozen in OP_FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (!r_halted && (w_phase == PH_OP_ADDR) && w_is_hlt) begin
            r_halted <= 1'b1;
        end
    end

    risc_phase_counter u_phase_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_hold   (w_hold),
        .i_freeze (r_halted),
        .o_phase  (w_phase)
    );

    // Strobe decode from registered phase and current opcode; halt masks everything
    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.wr     = 1'b0;
        bus.data_e = 1'b0;
        bus.halt   = 1'b0;
        if (r_halted) begin
            bus.halt = 1'b1;
        end else begin
            case (w_phase)
                PH_INST_ADDR: begin
                    bus.sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    bus.inc_pc = 1'b1;
                end
                PH_OP_FETCH: begin
                    bus.rd = w_aluop;
                end
                PH_ALU_OP: begin
                    bus.rd     = w_aluop;
                    bus.inc_pc = w_is_skz && bus.zero;
                    bus.ld_pc  = w_is_jmp;
                    bus.data_e = w_is_sto;
                end
                PH_STORE: begin
                    bus.rd     = w_aluop;
                    bus.ld_ac  = w_aluop;
                    bus.ld_pc  = w_is_jmp;
                    bus.inc_pc = w_is_jmp;
                    bus.wr     = w_is_sto;
                    bus.data_e = w_is_sto;
                end
                default: begin
                    bus.sel = 1'b0;
                end
            endcase
        end
    end

    assign bus.phase = w_phase;

endmodule
